// File: rtl/sdram_model.sv
// Synthesizable responder model of a 32Mx16 4-bank SDR SDRAM for exercising the picosoc controller.
// Define SDRAM_MODEL_ERRCHK_EN to compile in the sticky protocol-error flags and per-bank tRCD counters.
module sdram_model #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_data_in,
  output logic [15:0] sd_data_out,
  output logic        sd_data_oe,
  output logic [7:0]  err_flags,
  output logic [15:0] refresh_count
);

  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;

  typedef logic [MEM_AW-1:0] idx_t;
  typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_e;

  logic [3:0] cmd;
  logic       is_load, is_refresh, is_pre, is_active, is_write, is_read, is_bterm;
  logic       new_rw, cut, access_ok;

  assign cmd        = {sd_cs, sd_ras, sd_cas, sd_we};
  assign is_load    = (cmd == CMD_LOAD_MODE);
  assign is_refresh = (cmd == CMD_AUTO_REFRESH);
  assign is_pre     = (cmd == CMD_PRECHARGE);
  assign is_active  = (cmd == CMD_ACTIVE);
  assign is_write   = (cmd == CMD_WRITE);
  assign is_read    = (cmd == CMD_READ);
  assign is_bterm   = (cmd == CMD_BURST_TERM);
  assign new_rw     = is_read | is_write;
  assign cut        = new_rw | is_bterm;

  logic [2:0]        mode_cl;
  logic [2:0]        mode_bl;
  logic              mode_wr_single;
  logic              mode_valid;
  logic [3:0]        bank_open;
  logic [3:0][12:0]  bank_row;

  logic              cl_long;
  logic [7:0]        rd_last, wr_last, new_last;

  assign access_ok = bank_open[sd_ba] & mode_valid;
  assign cl_long   = (mode_cl >= 3'd3);
  assign rd_last   = (8'd1 << mode_bl) - 8'd1;
  assign wr_last   = mode_wr_single ? 8'd0 : rd_last;
  assign new_last  = is_write ? wr_last : rd_last;

  burst_e      burst_state;
  logic        burst_ap;
  logic [1:0]  burst_ba;
  logic [12:0] burst_row;
  logic [9:0]  burst_col;
  logic [7:0]  burst_k;
  logic [7:0]  burst_last;

  logic        p0_valid;
  idx_t        p0_idx;
  logic        rd_valid;
  logic [15:0] rd_data;

  function automatic idx_t make_idx(input logic [1:0] ba, input logic [12:0] row,
                                    input logic [9:0] col);
    return idx_t'({ba, row, col});
  endfunction

  // Sequential wrap: the low lg(BL) column bits count modulo BL inside the aligned block.
  function automatic logic [9:0] wrap_col(input logic [9:0] col, input logic [7:0] k,
                                          input logic [7:0] last);
    logic [9:0] m;
    m = {2'b00, last};
    return (col & ~m) | ((col + {2'b00, k}) & m);
  endfunction

  logic burst_go;
  idx_t burst_idx, cmd_idx;
  logic wr_en;
  idx_t wr_idx;
  logic rd_issue;
  idx_t rd_issue_idx;
  logic rd_sel_valid;
  idx_t rd_sel_idx;

  always_comb begin
    burst_go     = (burst_state != BURST_IDLE) && !cut;
    burst_idx    = make_idx(burst_ba, burst_row, wrap_col(burst_col, burst_k, burst_last));
    cmd_idx      = make_idx(sd_ba, bank_row[sd_ba], sd_addr[9:0]);
    wr_en        = 1'b0;
    wr_idx       = cmd_idx;
    rd_issue     = 1'b0;
    rd_issue_idx = cmd_idx;
    if (is_write && access_ok) begin
      wr_en = 1'b1;
    end else if (is_read && access_ok) begin
      rd_issue = 1'b1;
    end else if (burst_go) begin
      if (burst_state == BURST_WRITE) begin
        wr_en  = 1'b1;
        wr_idx = burst_idx;
      end else begin
        rd_issue     = 1'b1;
        rd_issue_idx = burst_idx;
      end
    end
    // CL 3 reads memory one edge later, from the first pipe stage.
    rd_sel_valid = cl_long ? p0_valid : rd_issue;
    rd_sel_idx   = cl_long ? p0_idx   : rd_issue_idx;
  end

  logic [7:0] mem_lo [1 << MEM_AW];
  logic [7:0] mem_hi [1 << MEM_AW];

  always_ff @(posedge clk) begin
    if (wr_en && !sd_dqm[0]) mem_lo[wr_idx] <= sd_data_in[7:0];
    if (wr_en && !sd_dqm[1]) mem_hi[wr_idx] <= sd_data_in[15:8];
    rd_data <= {mem_hi[rd_sel_idx], mem_lo[rd_sel_idx]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sd_data_out    <= '0;
      sd_data_oe     <= 1'b0;
      refresh_count  <= '0;
      mode_cl        <= 3'd2;
      mode_bl        <= 3'd0;
      mode_wr_single <= 1'b0;
      mode_valid     <= 1'b0;
      bank_open      <= '0;
      bank_row       <= '0;
      burst_state    <= BURST_IDLE;
      burst_ap       <= 1'b0;
      burst_ba       <= '0;
      burst_row      <= '0;
      burst_col      <= '0;
      burst_k        <= '0;
      burst_last     <= '0;
      p0_valid       <= 1'b0;
      p0_idx         <= '0;
      rd_valid       <= 1'b0;
    end else begin
      p0_valid    <= rd_issue;
      p0_idx      <= rd_issue_idx;
      rd_valid    <= rd_sel_valid;
      sd_data_oe  <= rd_valid;
      sd_data_out <= rd_valid ? rd_data : 16'h0000;

      // Burst ends on its last word or when cut; either way auto-precharge closes the bank.
      if (burst_go) begin
        if (burst_k == burst_last) begin
          burst_state <= BURST_IDLE;
          if (burst_ap) bank_open[burst_ba] <= 1'b0;
        end else begin
          burst_k <= burst_k + 8'd1;
        end
      end else if (burst_state != BURST_IDLE) begin
        burst_state <= BURST_IDLE;
        if (burst_ap) bank_open[burst_ba] <= 1'b0;
      end

      if (new_rw && access_ok) begin
        if (new_last == 8'd0) begin
          if (sd_addr[10]) bank_open[sd_ba] <= 1'b0;
        end else begin
          burst_state <= is_write ? BURST_WRITE : BURST_READ;
          burst_ap    <= sd_addr[10];
          burst_ba    <= sd_ba;
          burst_row   <= bank_row[sd_ba];
          burst_col   <= sd_addr[9:0];
          burst_k     <= 8'd1;
          burst_last  <= new_last;
        end
      end

      if (is_active) begin
        bank_open[sd_ba] <= 1'b1;
        bank_row[sd_ba]  <= sd_addr;
      end

      if (is_pre) begin
        if (sd_addr[10]) bank_open <= '0;
        else             bank_open[sd_ba] <= 1'b0;
      end

      if (is_load) begin
        mode_cl        <= sd_addr[6:4];
        mode_bl        <= sd_addr[2:0];
        mode_wr_single <= sd_addr[9];
        mode_valid     <= 1'b1;
      end

      if (is_refresh && refresh_count != 16'hFFFF) refresh_count <= refresh_count + 16'd1;
    end
  end

`ifdef SDRAM_MODEL_ERRCHK_EN
  localparam logic [7:0] TRCD_LOAD = (TRCD > 0) ? 8'(TRCD - 1) : 8'd0;

  logic [3:0][7:0] trcd_cnt;
  logic            read_pending;
  logic            bad_mode;

  assign read_pending = rd_valid | (cl_long & p0_valid);
  assign bad_mode     = (sd_addr[6:4] != 3'd2 && sd_addr[6:4] != 3'd3) ||
                        (sd_addr[2:0] > 3'd3) || sd_addr[3];

  // A non-zero counter at a READ/WRITE edge means fewer than TRCD edges since ACTIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      trcd_cnt  <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (trcd_cnt[2'(b)] != 8'd0) trcd_cnt[2'(b)] <= trcd_cnt[2'(b)] - 8'd1;
      end
      if (is_active) trcd_cnt[sd_ba] <= TRCD_LOAD;

      if (new_rw && !bank_open[sd_ba])                              err_flags[0] <= 1'b1;
      if (is_active && bank_open[sd_ba])                            err_flags[1] <= 1'b1;
      if (new_rw && !mode_valid)                                    err_flags[2] <= 1'b1;
      if (new_rw && bank_open[sd_ba] && trcd_cnt[sd_ba] != 8'd0)    err_flags[3] <= 1'b1;
      if (is_refresh && |bank_open)                                 err_flags[4] <= 1'b1;
      if (is_load && bad_mode)                                      err_flags[5] <= 1'b1;
      if (is_load && |bank_open)                                    err_flags[6] <= 1'b1;
      if (is_write && read_pending)                                 err_flags[7] <= 1'b1;
    end
  end
`else
  assign err_flags = 8'h00;
`endif

endmodule

// File: tb/tb_sdram_model.sv
// Directed self-checking bench for sdram_model: mode load, burst write/read, masks, wrap, errors, reset.
module tb_sdram_model;

  localparam logic [3:0] C_LOAD    = 4'b0000;
  localparam logic [3:0] C_REFRESH = 4'b0001;
  localparam logic [3:0] C_PRE     = 4'b0010;
  localparam logic [3:0] C_ACTIVE  = 4'b0011;
  localparam logic [3:0] C_WRITE   = 4'b0100;
  localparam logic [3:0] C_READ    = 4'b0101;
  localparam logic [3:0] C_NOP     = 4'b0111;
  localparam logic [3:0] C_INHIBIT = 4'b1111;

`ifdef SDRAM_MODEL_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_data_in;
  logic [15:0] sd_data_out;
  logic        sd_data_oe;
  logic [7:0]  err_flags;
  logic [15:0] refresh_count;

  int checks;
  int errors;

  sdram_model #(.MEM_AW(12), .TRCD(3)) dut (
    .clk(clk),
    .reset(reset),
    .sd_cs(sd_cs),
    .sd_ras(sd_ras),
    .sd_cas(sd_cas),
    .sd_we(sd_we),
    .sd_addr(sd_addr),
    .sd_ba(sd_ba),
    .sd_dqm(sd_dqm),
    .sd_data_in(sd_data_in),
    .sd_data_out(sd_data_out),
    .sd_data_oe(sd_data_oe),
    .err_flags(err_flags),
    .refresh_count(refresh_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_err(input logic [7:0] v);
    return ERRCHK ? v : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one command at a falling edge so the DUT samples it on the next rising edge.
  task automatic applyStimulus(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                               input logic [1:0] dqm, input logic [15:0] data);
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba      = ba;
    sd_addr    = addr;
    sd_dqm     = dqm;
    sd_data_in = data;
  endtask

  task automatic nop();
    applyStimulus(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
  endtask

  // After the i-th NOP the outputs reflect edge E+i-1; words land at i = cl and i = cl+1.
  task automatic readBurst(input string tag, input logic [1:0] ba, input logic [12:0] addr,
                           input int cl, input logic [15:0] w0, input logic [15:0] w1,
                           input bit driven);
    applyStimulus(C_READ, ba, addr, 2'b00, 16'h0000);
    for (int i = 1; i <= cl + 2; i++) begin
      nop();
      if (driven && i == cl) begin
        checkOutput($sformatf("%s oe%0d", tag, i), sd_data_oe, 1);
        checkOutput($sformatf("%s word0", tag), sd_data_out, w0);
      end else if (driven && i == cl + 1) begin
        checkOutput($sformatf("%s oe%0d", tag, i), sd_data_oe, 1);
        checkOutput($sformatf("%s word1", tag), sd_data_out, w1);
      end else begin
        checkOutput($sformatf("%s oe%0d", tag, i), sd_data_oe, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {sd_cs, sd_ras, sd_cas, sd_we} = C_INHIBIT;
    sd_ba = 2'd0; sd_addr = 13'd0; sd_dqm = 2'b00; sd_data_in = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset oe", sd_data_oe, 0);
    checkOutput("reset data", sd_data_out, 16'h0000);
    checkOutput("reset err", err_flags, 8'h00);
    checkOutput("reset refresh", refresh_count, 16'h0000);

    // CL 2, BL 2
    applyStimulus(C_LOAD, 2'd0, 13'h021, 2'b00, 16'h0000);
    nop();
    checkOutput("mode err", err_flags, 8'h00);

    applyStimulus(C_ACTIVE, 2'd1, 13'd5, 2'b00, 16'h0000);
    repeat (3) nop();
    applyStimulus(C_WRITE, 2'd1, 13'd8, 2'b00, 16'h1234);
    applyStimulus(C_NOP, 2'd0, 13'd0, 2'b00, 16'h5678);
    nop();
    readBurst("rd8", 2'd1, 13'd8, 2, 16'h1234, 16'h5678, 1'b1);

    // High byte masked on col 9; the wrapped second word to col 8 is fully masked.
    applyStimulus(C_WRITE, 2'd1, 13'd9, 2'b10, 16'hAAAA);
    applyStimulus(C_NOP, 2'd0, 13'd0, 2'b11, 16'hFFFF);
    nop();
    readBurst("rd9wrap", 2'd1, 13'd9, 2, 16'h56AA, 16'h1234, 1'b1);
    checkOutput("err clean", err_flags, 8'h00);

    readBurst("rdap", 2'd1, 13'h408, 2, 16'h1234, 16'h56AA, 1'b1);
    readBurst("rdclosed", 2'd1, 13'd8, 2, 16'h0000, 16'h0000, 1'b0);
    checkOutput("err closed", err_flags, exp_err(8'h01));

    applyStimulus(C_ACTIVE, 2'd1, 13'd5, 2'b00, 16'h0000);
    nop();
    readBurst("rdtrcd", 2'd1, 13'd8, 2, 16'h1234, 16'h56AA, 1'b1);
    checkOutput("err trcd", err_flags, exp_err(8'h09));

    applyStimulus(C_REFRESH, 2'd0, 13'd0, 2'b00, 16'h0000);
    nop();
    checkOutput("refresh count", refresh_count, 16'h0001);
    checkOutput("err refresh", err_flags, exp_err(8'h19));

    // Close everything, switch to CL 3 and reopen with exactly TRCD edges before the read.
    applyStimulus(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0000);
    applyStimulus(C_LOAD, 2'd0, 13'h031, 2'b00, 16'h0000);
    applyStimulus(C_ACTIVE, 2'd1, 13'd5, 2'b00, 16'h0000);
    nop();
    nop();
    readBurst("rdcl3", 2'd1, 13'd8, 3, 16'h1234, 16'h56AA, 1'b1);
    checkOutput("err cl3", err_flags, exp_err(8'h19));

    applyStimulus(C_READ, 2'd1, 13'd8, 2'b00, 16'h0000);
    nop();
    nop();
    nop();
    checkOutput("midburst oe", sd_data_oe, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset oe", sd_data_oe, 0);
    checkOutput("async reset data", sd_data_out, 16'h0000);
    checkOutput("async reset err", err_flags, 8'h00);
    checkOutput("async reset refresh", refresh_count, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Mode is invalid again after reset, so this read is dropped; n = TRCD must not flag tRCD.
    applyStimulus(C_ACTIVE, 2'd1, 13'd5, 2'b00, 16'h0000);
    nop();
    nop();
    readBurst("rdnomode", 2'd1, 13'd8, 2, 16'h0000, 16'h0000, 1'b0);
    checkOutput("err nomode", err_flags, exp_err(8'h04));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_model.md
# sdram_model

- Synthesizable responder model of a 32Mx16, 4-bank SDR SDRAM (AS4C32M16SA / MT48LC32M16 command set).
- Connects to the picosoc SDRAM controller's pins in simulation and in FPGA loopback builds, so the controller can be tested without a physical chip.
- Behaviour:
  - decodes CS/RAS/CAS/WE commands;
  - tracks per-bank open rows and the mode register;
  - returns read bursts at the programmed CAS latency from a folded on-chip memory;
  - applies DQM byte masks on writes;
  - raises sticky protocol-error flags.

## Interface
Parameters:
- MEM_AW, 12 — log2 of backing-store depth in 16-bit words.
- TRCD, 3 — minimum cycles from ACTIVE to READ/WRITE in the same bank.

Ports:
- clk  in  1  — SDRAM clock; all commands sampled on the rising edge.
- reset  in  1  — asynchronous, active-high.
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  — command pins. Command = {cs,ras,cas,we}.
- sd_addr  in  13  — row / column / mode bus; A10 = auto-precharge / all-banks.
- sd_ba  in  2  — bank select.
- sd_dqm  in  2  — write byte masks; 1 = byte masked.
- sd_data_in  in  16  — write data from the controller.
- sd_data_out  out  16  — read data.
- sd_data_oe  out  1  — high while a read word is driven.
- err_flags  out  8  — sticky protocol errors.
- refresh_count  out  16  — AUTO_REFRESH commands seen, saturating at 16'hFFFF.

## Operation
- Command decode:
  - 1111 INHIBIT, 0111 NOP: continue the active burst.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0110 BURST_TERMINATE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
- LOAD_MODE:
  - latches sd_addr[9:0];
  - CL = bits[6:4], BL = 1 << bits[2:0];
  - sets mode_valid.
- ACTIVE: records row = sd_addr for bank sd_ba and marks the bank open; starts that bank's tRCD counter.
- READ/WRITE:
  - column = sd_addr[9:0];
  - linear address = {ba, open_row, col}; index = linear[MEM_AW-1:0];
  - burst word k uses col[9:lg BL] with low bits (col + k) mod BL (sequential wrap within the BL-aligned block);
  - A10 = 1 closes the bank after the last word.
- WRITE:
  - word 0 is taken from sd_data_in on the command edge; words 1..BL-1 on the following edges;
  - sd_dqm[0] masks [7:0] and sd_dqm[1] masks [15:8], each masked byte leaving memory unchanged;
  - mode bit 9 = 1 forces BL = 1 for writes.
- READ: sd_dqm is ignored.
- A new READ/WRITE or BURST_TERMINATE cuts the current burst at that edge. Words already queued in the read pipe still come out.
- PRECHARGE: A10 = 1 closes all banks; otherwise closes bank sd_ba.
- AUTO_REFRESH: increments refresh_count.
- err_flags bits, set on the offending edge:
  - [0] READ/WRITE to a closed bank;
  - [1] ACTIVE to an open bank;
  - [2] READ/WRITE before mode_valid;
  - [3] tRCD violation;
  - [4] AUTO_REFRESH with any bank open;
  - [5] unsupported mode (CL not 2/3, BL code > 3, or bit3 interleaved);
  - [6] LOAD_MODE with any bank open;
  - [7] WRITE while read data is still pending in the pipe (bus contention).
- The offending command's effect still applies, except [0] and [2]: the access is dropped.

## Timing
- Reset values:
  - sd_data_out = 0, sd_data_oe = 0, err_flags = 0, refresh_count = 0;
  - all banks closed, mode_valid = 0, CL = 2, BL = 1, burst idle.
  - Memory contents are not cleared.
- Read latency: for a READ sampled on edge E, word k is driven from edge E + CL - 1 + k until edge E + CL + k. The controller samples word k at edge E + CL + k.
- sd_data_oe follows the same window.
- Read path is a CL-deep shift pipe of {valid, addr}. Memory is read one cycle ahead so sd_data_out is registered.
- A WRITE to the same index as a pending read word: the read returns the pre-write data only if its memory read already happened; otherwise it returns the new data. The bench does not check this case.
- A tRCD violation means READ/WRITE at edge A + n with n < TRCD after ACTIVE at edge A. n = TRCD is legal.
- Reset asserted mid-burst: pipe flushed and sd_data_oe low immediately (asynchronous).

## Configuration
- SDRAM_MODEL_ERRCHK_EN defined: err_flags logic and the tRCD counters are compiled in.
- Undefined:
  - err_flags is tied to 0 and the tRCD counters are removed;
  - accesses to closed banks or before LOAD_MODE are still dropped;
  - all other behaviour is identical.

## Test plan
- Reset, then LOAD_MODE 13'h021 (CL 2, BL 2) -> mode_valid; err_flags = 0.
- ACTIVE ba 1 row 5; WRITE col 8 after 3 NOPs with data 16'h1234, 16'h5678 and dqm 0 -> READ col 8 returns 1234 then 5678 on edges E+2 and E+3; sd_data_oe high exactly 2 cycles.
- WRITE col 9 with dqm 2'b10 and data 16'hAAAA over stored 5678 -> read of col 9 returns 56AA. Wrap check: READ col 9 with BL 2 returns col 9 then col 8.
- READ with A10 = 1, then READ to the same bank without ACTIVE -> err_flags[0] = 1; second read not driven (sd_data_oe stays low).
- ACTIVE then READ 2 cycles later with TRCD = 3 -> err_flags[3] = 1. AUTO_REFRESH with a bank open -> err_flags[4] = 1 and refresh_count = 1.
- LOAD_MODE 13'h031 (CL 3) then a read -> data on edges E+3 and E+4. Assert reset during the burst -> sd_data_oe = 0 at once; err_flags = 0.
